// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: RAW hazard detection, SRAM access
// sequencing with timeout, and branch flush scheduling across memory stalls.
module pipe_hazard_ctrl #(
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             use_src1,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             freeze_front,
  output logic             bubble_id,
  output logic             flush_if,
  output logic             freeze_back,
  output logic             sram_start,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WC_W-1:0]  cnt_r;
  logic [WC_W-1:0]  cnt_nxt_s;
  logic             pend_flush_r;
  logic             mem_err_r;
  logic [CNT_W-1:0] stall_r;

  logic hazard_s;
  logic fb_s;
  logic start_s;
  logic timeout_s;
  logic branch_s;
  logic ff_s;
  logic bub_s;

  // Source-vs-destination match; with forwarding only a load in EX can stall.
  function automatic logic src_match(
    input logic [REG_W-1:0] src,
    input logic             fwd,
    input logic             ex_wb,
    input logic [REG_W-1:0] ex_dst,
    input logic             ex_ld,
    input logic             mm_wb,
    input logic [REG_W-1:0] mm_dst
  );
    logic m;
    if (fwd) begin
      m = ex_ld & (src == ex_dst);
    end else begin
      m = (ex_wb & (src == ex_dst)) | (mm_wb & (src == mm_dst));
    end
    return m;
  endfunction

  // RAW hazard on the sources the ID instruction actually reads
  always_comb begin
    hazard_s = 1'b0;
    if (use_src1 && src_match(src1, fwd_en, exe_wb_en, exe_dest, exe_mem_r_en, mem_wb_en, mem_dest)) begin
      hazard_s = 1'b1;
    end else if (two_src && src_match(src2, fwd_en, exe_wb_en, exe_dest, exe_mem_r_en, mem_wb_en, mem_dest)) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  // SRAM sequencer next-state and back-end freeze
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    fb_s        = 1'b0;
    start_s     = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_req) begin
          start_s     = 1'b1;
          fb_s        = 1'b1;
          state_nxt_s = WAIT;
          cnt_nxt_s   = {WC_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        fb_s      = 1'b1;
        cnt_nxt_s = cnt_r + WC_W'(1);
        if (sram_ready) begin
          state_nxt_s = DONE;
        end else if (cnt_r == WC_W'(TIMEOUT - 1)) begin
          timeout_s   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      // Result is consumed here; a new request waits for IDLE.
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Branch overrides hazard; a branch seen during a memory stall is deferred
  always_comb begin
    branch_s = (branch_taken | pend_flush_r) & ~fb_s;
    ff_s     = fb_s | (hazard_s & ~branch_s);
    bub_s    = (hazard_s & ~fb_s) | branch_s;
  end

  // Sequencer, deferred flush, error flag and stall counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {WC_W{1'b0}};
      pend_flush_r <= 1'b0;
      mem_err_r    <= 1'b0;
      stall_r      <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (branch_s) begin
        pend_flush_r <= 1'b0;
      end else if (branch_taken && fb_s) begin
        pend_flush_r <= 1'b1;
      end else begin
        pend_flush_r <= pend_flush_r;
      end
      if (timeout_s) begin
        mem_err_r <= 1'b1;
      end else begin
        mem_err_r <= mem_err_r;
      end
      if (ff_s && (stall_r != {CNT_W{1'b1}})) begin
        stall_r <= stall_r + CNT_W'(1);
      end else begin
        stall_r <= stall_r;
      end
    end
  end

  assign freeze_front = ff_s & ~rst;
  assign bubble_id    = bub_s & ~rst;
  assign flush_if     = branch_s & ~rst;
  assign freeze_back  = fb_s & ~rst;
  assign sram_start   = start_s & ~rst;
  assign mem_err      = mem_err_r;
  assign stall_cycles = stall_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a behavioural model pushes expected
// outputs per cycle; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int REG_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int VW      = CNT_W + 6;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [REG_W-1:0] src1, src2, exe_dest, mem_dest;
  logic use_src1, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en;
  logic branch_taken, mem_req, sram_ready;
  logic freeze_front, bubble_id, flush_if, freeze_back, sram_start, mem_err;
  logic [CNT_W-1:0] stall_cycles;

  pipe_hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .use_src1(use_src1),
    .two_src(two_src), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
    .exe_mem_r_en(exe_mem_r_en), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .fwd_en(fwd_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .sram_ready(sram_ready), .freeze_front(freeze_front), .bubble_id(bubble_id),
    .flush_if(flush_if), .freeze_back(freeze_back), .sram_start(sram_start),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: memory access is "busy" for the waited cycles, followed
  // by one "done" cycle; a branch blocked by the memory stall is remembered.
  bit m_busy, m_done, m_pend, m_err;
  int m_wait, m_stall;

  function automatic bit reads_stale(input logic [REG_W-1:0] s);
    if (fwd_en) return exe_mem_r_en && (s == exe_dest);
    return (exe_wb_en && (s == exe_dest)) || (mem_wb_en && (s == mem_dest));
  endfunction

  task automatic step();
    logic [VW-1:0] e;
    bit hz, fb, st, bo, ff, bub;
    if (rst) begin
      e = '0;
      m_busy = 0; m_done = 0; m_pend = 0; m_err = 0; m_wait = 0; m_stall = 0;
    end else begin
      hz  = (use_src1 && reads_stale(src1)) || (two_src && reads_stale(src2));
      st  = !m_busy && !m_done && mem_req;
      fb  = st || m_busy;
      bo  = (branch_taken || m_pend) && !fb;
      ff  = fb || (hz && !bo);
      bub = (hz && !fb) || bo;
      e = {ff, bub, bo, fb, st, m_err, CNT_W'(m_stall)};
      if (st) begin
        m_busy = 1; m_wait = 0;
      end else if (m_busy) begin
        if (sram_ready) begin
          m_busy = 0; m_done = 1;
        end else if (m_wait == TIMEOUT - 1) begin
          m_busy = 0; m_done = 1; m_err = 1;
        end else begin
          m_wait++;
        end
      end else if (m_done) begin
        m_done = 0;
      end
      if (bo) m_pend = 0;
      else if (branch_taken && fb) m_pend = 1;
      if (ff && m_stall < STALL_MAX) m_stall++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    src1 = '0; src2 = '0; exe_dest = '0; mem_dest = '0;
    use_src1 = 0; two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
    fwd_en = 0; branch_taken = 0; mem_req = 0; sram_ready = 0;
  endtask

  // Monitor: outputs are presented every cycle; compare against queue head
  always @(negedge clk) begin
    logic [VW-1:0] e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {freeze_front, bubble_id, flush_if, freeze_back, sram_start, mem_err, stall_cycles};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got ff,bub,flush,fb,start,err=%b stall=%0d, want %b stall=%0d",
                 cyc, a[VW-1:CNT_W], a[CNT_W-1:0], e[VW-1:CNT_W], e[CNT_W-1:0]);
      end
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(); step();
    rst = 1'b0;

    // RAW without forwarding, then the same source unused
    fwd_en = 1; exe_wb_en = 1; exe_dest = 4'd3; src1 = 4'd3; use_src1 = 1; fwd_en = 0;
    step();
    use_src1 = 0; step();

    // load-use with forwarding, then non-load in EX
    clr(); fwd_en = 1; exe_mem_r_en = 1; exe_dest = 4'd5; src2 = 4'd5; two_src = 1;
    step();
    clr(); step();
    fwd_en = 1; exe_wb_en = 1; exe_dest = 4'd5; src2 = 4'd5; two_src = 1;
    step();

    // SRAM handshake: ready on the fourth cycle after the request
    clr(); mem_req = 1; step();
    step(); step(); step();
    sram_ready = 1; step();
    sram_ready = 0; mem_req = 0; step();
    step();

    // timeout, sticky error, cleared only by reset
    clr(); mem_req = 1; step();
    repeat (TIMEOUT) step();
    mem_req = 0; step();
    repeat (3) step();
    rst = 1; step();
    rst = 0; step();

    // branch arriving during the memory stall
    clr(); mem_req = 1; step();
    step();
    branch_taken = 1; step();
    step();
    sram_ready = 1; step();
    sram_ready = 0; mem_req = 0; branch_taken = 0; step();
    step();

    // branch together with a hazard
    clr(); exe_wb_en = 1; exe_dest = 4'd7; src1 = 4'd7; use_src1 = 1; branch_taken = 1;
    step();
    branch_taken = 0; step();

    // reset in the middle of a wait, request still asserted afterwards
    clr(); mem_req = 1; step(); step(); step();
    rst = 1; step();
    rst = 0; step(); step(); sram_ready = 1; step();
    clr(); step();

    // stall counter saturation
    mem_wb_en = 1; mem_dest = 4'd9; src2 = 4'd9; two_src = 1;
    repeat (20) step();
    clr(); step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(199) == 0);
      src1         = REG_W'($urandom_range(3));
      src2         = REG_W'($urandom_range(3));
      exe_dest     = REG_W'($urandom_range(3));
      mem_dest     = REG_W'($urandom_range(3));
      use_src1     = $urandom_range(1);
      two_src      = $urandom_range(1);
      exe_wb_en    = $urandom_range(1);
      exe_mem_r_en = $urandom_range(1);
      mem_wb_en    = $urandom_range(1);
      fwd_en       = $urandom_range(1);
      branch_taken = ($urandom_range(7) == 0);
      mem_req      = ($urandom_range(2) != 0);
      sram_ready   = ($urandom_range(5) == 0);
      step();
    end
    rst = 0; clr(); step(); step();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage ARM core. It generates freeze/flush controls for the PC, the IF/ID register, the ID/EX register and the EX/MEM and MEM/WB registers. It detects RAW hazards in ID and sequences multi-cycle SRAM accesses from MEM with a start/ready handshake and a timeout. It also schedules branch flushes, including a branch that resolves during a memory stall.

Parameters:
REG_W, 4, register index width
TIMEOUT, 64, max SRAM wait cycles before abort (>=2)
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
src1  in  REG_W  ID source Rn
src2  in  REG_W  ID source Rm/Rd
use_src1  in  1  ID instruction reads src1
two_src  in  1  ID instruction reads src2
exe_wb_en  in  1  EX instruction writes back
exe_dest  in  REG_W  EX destination
exe_mem_r_en  in  1  EX instruction is a load
mem_wb_en  in  1  MEM instruction writes back
mem_dest  in  REG_W  MEM destination
fwd_en  in  1  forwarding unit active
branch_taken  in  1  branch resolved taken in EX
mem_req  in  1  MEM stage needs SRAM access (level, held until served)
sram_ready  in  1  SRAM access complete (1-cycle pulse)
freeze_front  out  1  freeze PC and IF/ID register
bubble_id  out  1  clear ID/EX register (insert NOP)
flush_if  out  1  clear IF/ID register
freeze_back  out  1  freeze EX/MEM, MEM/WB, ID/EX
sram_start  out  1  1-cycle SRAM start pulse
mem_err  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with freeze_front=1

Behaviour:
- Reset (async): state=IDLE, wait counter=0, pend_flush=0, mem_err=0, stall_cycles=0. All outputs are 0 while rst=1.
- hazard (combinational):
  - fwd_en=0: match against exe_dest while exe_wb_en, or against mem_dest while mem_wb_en.
  - fwd_en=1: match against exe_dest only, and only while exe_mem_r_en.
  - A match counts only on a used source: src1 when use_src1, src2 when two_src.
- FSM, states IDLE, WAIT, DONE:
  - IDLE, mem_req=1: sram_start=1 for that cycle; next state WAIT, counter=0.
  - WAIT: counter increments each cycle.
    - sram_ready=1: next state DONE.
    - Else counter==TIMEOUT-1: mem_err<=1, next state DONE.
  - DONE: lasts one cycle, no stall; MEM result is consumed. Next state IDLE. mem_req is ignored in DONE, so a new request can start no earlier than the following cycle.
- freeze_back=1 in IDLE when mem_req=1, and in WAIT. It is 0 in DONE.
- freeze_front = freeze_back | (hazard & ~branch_out).
- bubble_id = (hazard & ~freeze_back) | branch_out. Hazard stalls the front end and inserts one NOP per stalled cycle.
- branch_out = (branch_taken | pend_flush) & ~freeze_back.
- flush_if = branch_out.
  - Branch overrides hazard: flush and bubble win, and PC loads the target.
- pend_flush:
  - Set when branch_taken=1 while freeze_back=1.
  - Cleared in the cycle branch_out=1.
  - branch_taken is ignored while pend_flush=1 and freeze_back=1, because EX is frozen and the same branch is held.
- stall_cycles increments on every cycle with freeze_front=1 and saturates at all-ones.
- mem_err is cleared only by rst.
- Reset mid-WAIT: the SRAM transaction is abandoned, state returns to IDLE, and no sram_start is issued until rst deasserts and mem_req is sampled.
- sram_ready outside WAIT is ignored.

Test Plan:
- No-forward RAW: fwd_en=0, exe_wb_en=1, exe_dest=3, src1=3, use_src1=1 -> freeze_front=1, bubble_id=1 the same cycle. With use_src1=0 -> both 0.
- Load-use with forwarding: fwd_en=1, exe_mem_r_en=1, exe_dest=5, src2=5, two_src=1 -> one stall cycle and stall_cycles=1. Same case with exe_mem_r_en=0 -> no stall.
- SRAM handshake: mem_req rises at cycle 0, sram_ready at cycle 4 ->
  - sram_start high only at cycle 0.
  - freeze_back high cycles 0-4, low at cycle 5 (DONE).
  - Back in IDLE at cycle 6.
- Timeout: mem_req=1, sram_ready never -> DONE after TIMEOUT wait cycles, mem_err=1 and sticky; a later rst clears it.
- Branch during stall: branch_taken=1 at cycle 2 of WAIT -> flush_if=0 during the stall, then flush_if=1 and bubble_id=1 exactly in the DONE cycle, and pend_flush clears.
- Branch with hazard: branch_taken=1 and hazard=1 in the same cycle -> flush_if=1, bubble_id=1, freeze_front=0.
